// File: rtl/mul35_issue_pacer_if.sv
// mul35_issue_pacer_if: operand-pair stream in, issue strobe and operands out to the 35x35 multiplier.
interface mul35_issue_pacer_if;
   logic        i_valid;
   logic        o_ready;
   logic [34:0] i_a;
   logic [34:0] i_b;
   logic        o_en;
   logic [34:0] o_a;
   logic [34:0] o_b;
   modport master (output i_valid, i_a, i_b, input o_ready, o_en, o_a, o_b);
   modport slave (input i_valid, i_a, i_b, output o_ready, o_en, o_a, o_b);
endinterface

// File: rtl/mul35_issue_pacer.sv
// mul35_issue_pacer: FIFO-buffered feeder issuing operand pairs at least ISSUE_GAP cycles apart.
// Define MUL35_PACER_LEVEL_EN to add o_level/o_hwm occupancy outputs.
module mul35_issue_pacer #(
   parameter int ADDR_W    = 3,
   parameter int ISSUE_GAP = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   mul35_issue_pacer_if.slave  s
`ifdef MUL35_PACER_LEVEL_EN
   ,
   output logic [ADDR_W:0]     o_level,
   output logic [ADDR_W:0]     o_hwm
`endif
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [3:0] GAP_M1 = 4'(ISSUE_GAP - 1);
   logic [69:0]       mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_nxt;
   logic [3:0]        gap_cnt;
   logic              push;
   logic              pop;
   // ready depends only on registered state, never on i_valid
   always_comb begin
      s.o_ready = !i_rst && (count != (ADDR_W+1)'(DEPTH));
      push      = s.i_valid && s.o_ready;
      pop       = (count != '0) && (gap_cnt == '0);
      count_nxt = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
   end
   always_ff @(posedge i_clk)
      if (push) mem[wr_ptr] <= {s.i_a, s.i_b};
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         gap_cnt <= '0;
         s.o_en  <= 1'b0;
         s.o_a   <= '0;
         s.o_b   <= '0;
      end else begin
         wr_ptr  <= wr_ptr + ADDR_W'(push);
         rd_ptr  <= rd_ptr + ADDR_W'(pop);
         count   <= count_nxt;
         gap_cnt <= pop ? GAP_M1 : gap_cnt - 4'(gap_cnt != '0);
         s.o_en  <= pop;
         if (pop) begin
            s.o_a <= mem[rd_ptr][69:35];
            s.o_b <= mem[rd_ptr][34:0];
         end
      end
`ifdef MUL35_PACER_LEVEL_EN
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         o_level <= '0;
         o_hwm   <= '0;
      end else begin
         o_level <= count_nxt;
         o_hwm   <= (count_nxt > o_hwm) ? count_nxt : o_hwm;
      end
`endif
endmodule

// File: tb/tb_mul35_issue_pacer.sv
// tb_mul35_issue_pacer: scoreboard bench; model schedules each pair at max(accept+1, prev_issue+GAP).
module tb_mul35_issue_pacer;
   localparam int GAP   = 4;
   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
   logic clk = 1'b0;
   logic rst = 1'b1;
   mul35_issue_pacer_if bus ();
`ifdef MUL35_PACER_LEVEL_EN
   logic [AW:0] level;
   logic [AW:0] hwm;
`endif
   mul35_issue_pacer #(.ADDR_W(AW), .ISSUE_GAP(GAP)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .s(bus)
`ifdef MUL35_PACER_LEVEL_EN
      ,
      .o_level(level),
      .o_hwm(hwm)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {
      logic [34:0] a;
      logic [34:0] b;
      int          k;
      int          e;
   } item_t;
   item_t q[$];
   int cyc = 0;
   int last_e = -1000;
   int n_cmp = 0;
   int n_bad = 0;
   int hwm_m = 0;
   logic in_rst = 1'b1;
   logic [34:0] last_a = '0;
   logic [34:0] last_b = '0;
   always @(posedge clk) cyc++;
   task automatic chk(string nm, logic [69:0] act, logic [69:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask
   // monitor: outputs seen here reflect the edge numbered cyc
   always @(negedge clk) begin
      int lvl;
      item_t it;
      #3;
      if (in_rst) begin
         chk("rst_en", 70'(bus.o_en), 70'(0));
         chk("rst_ready", 70'(bus.o_ready), 70'(0));
      end else begin
         lvl = 0;
         foreach (q[i]) if (q[i].k <= cyc && q[i].e > cyc) lvl++;
         chk("ready", 70'(bus.o_ready), 70'(lvl < DEPTH));
`ifdef MUL35_PACER_LEVEL_EN
         if (lvl > hwm_m) hwm_m = lvl;
         chk("level", 70'(level), 70'(lvl));
         chk("hwm", 70'(hwm), 70'(hwm_m));
`endif
         if (bus.o_en) begin
            if (q.size() == 0) chk("spurious_en", 70'(bus.o_en), 70'(0));
            else begin
               it = q.pop_front();
               chk("issue_cycle", 70'(cyc), 70'(it.e));
               chk("pair", {bus.o_a, bus.o_b}, {it.a, it.b});
               last_a = it.a;
               last_b = it.b;
            end
         end else begin
            if (q.size() != 0 && q[0].e == cyc) chk("missing_en", 70'(bus.o_en), 70'(1));
            chk("hold", {bus.o_a, bus.o_b}, {last_a, last_b});
         end
      end
   end
   task automatic send(logic [34:0] a, logic [34:0] b);
      int t;
      item_t it;
      t = 0;
      @(negedge clk);
      bus.i_valid = 1'b1;
      bus.i_a = a;
      bus.i_b = b;
      #1;
      while (!bus.o_ready && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (!bus.o_ready) chk("send_timeout", 70'(bus.o_ready), 70'(1));
      else begin
         it.a = a;
         it.b = b;
         it.k = cyc + 1;
         it.e = (it.k + 1 > last_e + GAP) ? it.k + 1 : last_e + GAP;
         last_e = it.e;
         q.push_back(it);
      end
   endtask
   task automatic idle(int n);
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask
   task automatic drain();
      int t;
      t = 0;
      idle(1);
      while (q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (GAP + 2) @(negedge clk);
      chk("drain", 70'(q.size()), 70'(0));
   endtask
   task automatic do_reset();
      @(negedge clk);
      bus.i_valid = 1'b0;
      #2;
      rst = 1'b1;
      in_rst = 1'b1;
      #1;
      chk("rst_now_en", 70'(bus.o_en), 70'(0));
      chk("rst_now_ab", {bus.o_a, bus.o_b}, 70'(0));
      chk("rst_now_ready", 70'(bus.o_ready), 70'(0));
      q.delete();
      last_e = -1000;
      last_a = '0;
      last_b = '0;
      hwm_m = 0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      in_rst = 1'b0;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.i_valid = 1'b0;
      bus.i_a = '0;
      bus.i_b = '0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      in_rst = 1'b0;
      send(35'd3, 35'd5);
      drain();
      for (int i = 1; i <= 4; i++) send(35'(i), 35'(10 * i));
      drain();
      for (int i = 0; i < 12; i++) send(35'(100 + i), 35'(200 + i));
      drain();
      send(35'h4_0000_0000, 35'h3_FFFF_FFFF);
      drain();
      for (int i = 0; i < 5; i++) send(35'(50 + i), 35'(60 + i));
      do_reset();
      send(35'd7, 35'd9);
      drain();
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 2) != 0) send(35'({$urandom(), $urandom()}), 35'({$urandom(), $urandom()}));
         else idle($urandom_range(1, 3));
      end
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
